uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 17 +
 rtl/baud_tick.sv | 36 +++
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART blocks (uart_tx today, uart_rx later).
//   DEFAULT_CLKS_PER_BIT : clock cycles per bit, 115200 baud from a 50 MHz clock
//   uart_state_t         : frame state encoding
//   ST_*                 : frame states (IDLE -> START -> DATA -> [PARITY] -> STOP)
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/baud_tick.sv
// baud_tick -- bit-period counter for the UART.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high during the cycle in which
// the count is CLKS_PER_BIT-1, i.e. the last cycle of a bit period.
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   restart : hold the counter at 0 (the next cycle begins a new bit period)
//   tick    : last cycle of the current bit period
module baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1/8N2 UART transmitter with ready/valid byte input.
// Optional parity bit: define UART_TX_PARITY_EN (PARITY_ODD selects odd parity).
//   CLK_50M  : system clock
//   RST_N    : asynchronous active-low reset
//   tx_data  : byte to send, captured on acceptance
//   tx_valid : producer has a byte
//   tx_ready : idle, a byte can be accepted this cycle
//   tx_done  : one-cycle pulse on the final cycle of the last stop bit
//   TX       : serial line, idle high
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       TX
);

    // Elaboration-time parameter legality checks.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be 2..65535");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_state_t state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic        tx_q;
    logic        tick;
    logic        accept;
    logic        last_stop;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_INV = (PARITY_ODD != 0);
    // Parity is computed from the whole byte at acceptance, since the shift
    // register is consumed as the data bits go out.
    logic par_q;
`endif

    assign tx_ready  = (state == ST_IDLE);
    assign accept    = tx_valid && tx_ready;
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    assign tx_done   = (state == ST_STOP) && tick && last_stop;
    // Registered line output: glitch-free, and async reset drives it high at once.
    assign TX        = tx_q;

    // Counter sits at 0 while idle, so the bit period starts with acceptance.
    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk     (CLK_50M),
        .rst_n   (RST_N),
        .restart (state == ST_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_START;
                        shreg    <= tx_data;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_q    <= (^tx_data) ^ PAR_INV;
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx_q  <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx_q  <= par_q;
`else
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx_q  <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (last_stop) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx with CLKS_PER_BIT=4.
// dut1: STOP_BITS=1, even parity; dut2: STOP_BITS=2, odd parity.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       sel      = 1'b0;

    logic ready1, done1, tx1;
    logic ready2, done2, tx2;
    logic ready_o, done_o, tx_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
        .CLK_50M (clk),
        .RST_N   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid & ~sel),
        .tx_ready(ready1),
        .tx_done (done1),
        .TX      (tx1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
        .CLK_50M (clk),
        .RST_N   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid & sel),
        .tx_ready(ready2),
        .tx_done (done2),
        .TX      (tx2)
    );

    assign ready_o = sel ? ready2 : ready1;
    assign done_o  = sel ? done2  : done1;
    assign tx_o    = sel ? tx2    : tx1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge with the selected DUT idle. Sends d, checks every
    // cycle of the frame, and returns at the negedge of the cycle after tx_done.
    // nv/nd: tx_valid/tx_data applied right after acceptance.
    // glitch_k > 0: pulse tx_valid with 0xFF on frame cycle glitch_k.
    task automatic frame(input logic [7:0] d, input int nstop, input logic odd,
                         input logic nv, input logic [7:0] nd, input int glitch_k);
        int   nb;
        int   nc;
        int   idx;
        logic e;
        nb = 10 + PAR + nstop - 1;
        nc = nb * CPB;
        chk("ready_before", ready_o, 8'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = nv;
        tx_data  = nd;
        for (int k = 1; k <= nc; k++) begin
            if (glitch_k > 0 && k == glitch_k) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (glitch_k > 0 && k == glitch_k + 1) tx_valid = 1'b0;
            idx = (k - 1) / CPB;
            if (idx == 0)                    e = 1'b0;
            else if (idx <= 8)               e = d[idx-1];
            else if (PAR == 1 && idx == 9)   e = (^d) ^ odd;
            else                             e = 1'b1;
            chk("tx_bit", tx_o, 8'(e));
            chk("tx_done", done_o, 8'(k == nc));
            chk("ready_busy", ready_o, 8'd0);
            @(negedge clk);
        end
        chk("idle_tx", tx_o, 8'd1);
        chk("ready_after", ready_o, 8'd1);
        chk("done_after", done_o, 8'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx1", tx1, 8'd1);
        chk("rst_ready1", ready1, 8'd1);
        chk("rst_done1", done1, 8'd0);
        chk("rst_tx2", tx2, 8'd1);
        chk("rst_ready2", ready2, 8'd1);
        chk("rst_done2", done2, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: 0x55, tx_done 40 cycles after acceptance (no parity)
        sel = 1'b0;
        frame(8'h55, 1, 1'b0, 1'b0, 8'h00, 0);
`ifdef UART_TX_PARITY_EN
        // Even parity of 0x07 is 1
        frame(8'h07, 1, 1'b0, 1'b0, 8'h00, 0);
`endif

        // Back-to-back with tx_valid held: one idle-high cycle between frames
        frame(8'hA5, 1, 1'b0, 1'b1, 8'h3C, 0);
        frame(8'h3C, 1, 1'b0, 1'b0, 8'h00, 0);

        // 0xFF offered mid-frame is ignored; data changes after acceptance too
        frame(8'h12, 1, 1'b0, 1'b0, 8'h00, 13);
        repeat (3) @(negedge clk);

        // Reset during DATA bit 3 (frame cycles 17..20) of 0xF0
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_reset_tx", tx1, 8'd0);
        rst_n = 1'b0;
        #1;
        chk("reset_tx", tx1, 8'd1);
        chk("reset_ready", ready1, 8'd1);
        chk("reset_done", done1, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 48; k++) begin
            chk("post_reset_done", done1, 8'd0);
            chk("post_reset_tx", tx1, 8'd1);
            @(negedge clk);
        end
        frame(8'h81, 1, 1'b0, 1'b0, 8'h00, 0);

        // Two stop bits (and odd parity of 0x00 = 1 when parity built in)
        sel = 1'b1;
        @(negedge clk);
        frame(8'h00, 2, 1'b1, 1'b0, 8'h00, 0);
        frame(8'hC3, 2, 1'b1, 1'b0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
